spi_sclk_gen: RTL and testbench
===============================

# spi_sclk_gen

Programmable SPI serial-clock and transfer-timing generator for the SPI master. It replaces the fixed-divisor prescaler with runtime control of divisor, bits per transfer and SPI mode (CPOL/CPHA). It produces the bus clock `sclk`, an active-low chip select, and single-cycle `sample` and `shift` strobes that sequence the master's shift register. It sits between the register interface and the SPI master datapath, one instance per SPI port.

## Interface
- `DIV_W`, 16: width of the `div` input.
- `CNT_W`, 6: width of `nbits`; maximum transfer is 2^CNT_W − 1 bits.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `div`  in  DIV_W  half-period of `sclk` minus 1, in `clk` cycles. `div`=0 gives `sclk` = fclk/2.
- `cpol`  in  1  `sclk` idle level.
- `cpha`  in  1  0: sample on leading edge; 1: sample on trailing edge.
- `nbits`  in  CNT_W  bits in the transfer.
- `start`  in  1  request a transfer; sampled in IDLE only.
- `abort`  in  1  cancel the current transfer.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at normal completion.
- `cs_n`  out  1  chip select, low while `busy`.
- `sclk`  out  1  SPI clock.
- `sample`  out  1  one-cycle strobe aligned with a sampling edge.
- `shift`  out  1  one-cycle strobe aligned with a shifting edge.

## Operation
- States: IDLE, RUN. With `SPI_SCLK_GEN_GUARD_EN`, SETUP and HOLD are added.
- **IDLE**
  - `sclk` is registered from `cpol` every cycle.
  - `start`=1, `abort`=0 and `nbits`≠0 latch `div`, `cpol`, `cpha` and `nbits`. The next state is RUN (or SETUP), `busy`=1, `cs_n`=0, half-period counter `hc`=0, edge counter `ec`=0.
  - `start` with `nbits`=0 moves to no state other than IDLE; it produces a `done` pulse the next cycle, and `busy` and `cs_n` do not change.
- **RUN**
  - `hc` counts 0..div_l. When `hc`==div_l:
    - `hc` is cleared, `sclk` toggles and `ec` increments.
    - The edge is leading if the new `ec` is odd, trailing if it is even.
  - With cpha=0: `sample` on every leading edge, `shift` on every trailing edge except edge 2·n.
  - With cpha=1: `shift` on every leading edge, `sample` on every trailing edge.
  - When `ec` reaches 2·n (where n is the latched `nbits`), the next state is IDLE (or HOLD).
- **Exit** (to IDLE from RUN or HOLD): on the next cycle `busy`=0, `cs_n`=1, `done`=1 for exactly one cycle.
- **Latched values**: changes to `div`, `cpol`, `cpha` or `nbits` while `busy` have no effect on the current transfer.
- **start while busy**: ignored.
- **abort in any non-IDLE state**: on the next cycle the state is IDLE, `sclk`=cpol_l, `cs_n`=1, `busy`=0, no `done`, no strobes.
- **abort and start together in IDLE**: `abort` wins and the transfer is not started.
- **Counter widths**: `hc` is DIV_W bits and `ec` is CNT_W+1 bits; no wrap is possible.
- **Asynchronous reset** (also mid-transfer): state IDLE, `sclk`=0, `cs_n`=1, `busy`=0, `done`=0, `sample`=0, `shift`=0, and all counters 0.

## Timing
- `start` is sampled at edge T. `busy`/`cs_n` are visible in cycle T+1.
- Edge k (1..2n) is visible in cycle T+1+k·(div+1), with its strobe asserted in that same cycle.
- The last edge is at T+1+2n·(div+1). `done`, `busy`=0 and `cs_n`=1 are at T+2+2n·(div+1).
- `sclk` period is 2·(div+1) clk cycles, 50 % duty.
- All outputs are registered; there is no combinational input→output path.

## Configuration
- `SPI_SCLK_GEN_GUARD_EN` defined:
  - A SETUP state of div_l+1 cycles is inserted after `start`, with `cs_n` low and `sclk` idle.
  - A HOLD state of div_l+1 cycles is inserted after the last edge.
  - All edge times shift by +(div+1); `done` is at T+2+(2n+2)·(div+1).
- Undefined: SETUP and HOLD do not exist, and the timing is as in Timing above.

## Test plan
- Mode 0, `div`=1, `nbits`=8, `start` at T → `sclk` period 4, 16 edges, 8 `sample` strobes on rising edges, 7 `shift` strobes, `done` at T+34, `cs_n` low T+1..T+33.
- Mode 3 (`cpol`=1, `cpha`=1), `div`=0, `nbits`=3 → `sclk` idles 1, 6 edges at T+2..T+7, `shift` at T+2/T+4/T+6, `sample` at T+3/T+5/T+7, `done` at T+8.
- `nbits`=0 with `start` → `done` at T+1, `busy` and `cs_n` never change.
- `abort` at edge 5 of an 8-bit transfer → next cycle IDLE, `sclk`=cpol, `cs_n`=1, no `done`. A new `start` afterwards runs normally.
- `rst` asserted mid-transfer → all outputs immediately at reset values. `start` pulses and `div` changes while `busy` → the current transfer timing is unchanged.
- With `SPI_SCLK_GEN_GUARD_EN`, `div`=1, `nbits`=2 → first edge at T+5, `done` at T+14.

Source files
------------

// File: rtl/spi_sclk_gen_if.sv
// Control/status bundle between the SPI register block (master) and spi_sclk_gen (slave).
// Carries transfer configuration, start/abort requests and the generated clock, chip select and strobes.
interface spi_sclk_gen_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 6
);
  logic [DIV_W-1:0] div;
  logic             cpol;
  logic             cpha;
  logic [CNT_W-1:0] nbits;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             cs_n;
  logic             sclk;
  logic             sample;
  logic             shift;

  modport master (
    output div, cpol, cpha, nbits, start, abort,
    input  busy, done, cs_n, sclk, sample, shift
  );

  modport slave (
    input  div, cpol, cpha, nbits, start, abort,
    output busy, done, cs_n, sclk, sample, shift
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// Programmable SPI sclk / chip-select / sample-shift strobe generator, all outputs registered.
// Define SPI_SCLK_GEN_GUARD_EN to add cs_n setup and hold phases of div+1 cycles around the clock burst.
module spi_sclk_gen #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 6
) (
  input logic           clk,
  input logic           rst,
  spi_sclk_gen_if.slave bus
);
  // state | meaning
  // IDLE  | sclk follows cpol, waiting for start
  // SETUP | cs_n low, sclk idle for div_l+1 cycles (guard build only)
  // RUN   | sclk toggles every div_l+1 cycles until 2*nbits_l edges
  // HOLD  | cs_n low after the last edge for div_l+1 cycles (guard build only)
`ifdef SPI_SCLK_GEN_GUARD_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_SETUP = 2'd2, S_HOLD = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1} state_t;
`endif

  state_t           state, state_nxt;
  logic [DIV_W-1:0] hc, hc_nxt, div_l, div_l_nxt;
  logic [CNT_W:0]   ec, ec_nxt, ec_inc, ec_last;
  logic [CNT_W-1:0] nbits_l, nbits_l_nxt;
  logic             cpol_l, cpol_l_nxt, cpha_l, cpha_l_nxt;
  logic             sclk_q, sclk_nxt, busy_q, busy_nxt, cs_n_q, cs_n_nxt;
  logic             done_q, done_nxt, sample_q, sample_nxt, shift_q, shift_nxt;
  logic             go, empty_go, hc_tc;

  assign go       = bus.start && !bus.abort && (bus.nbits != '0);
  assign empty_go = bus.start && !bus.abort && (bus.nbits == '0);
  assign hc_tc    = (hc == div_l);
  assign ec_inc   = ec + 1'b1;
  assign ec_last  = {nbits_l, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      hc       <= '0;
      ec       <= '0;
      div_l    <= '0;
      nbits_l  <= '0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      sclk_q   <= 1'b0;
      busy_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      done_q   <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hc       <= hc_nxt;
      ec       <= ec_nxt;
      div_l    <= div_l_nxt;
      nbits_l  <= nbits_l_nxt;
      cpol_l   <= cpol_l_nxt;
      cpha_l   <= cpha_l_nxt;
      sclk_q   <= sclk_nxt;
      busy_q   <= busy_nxt;
      cs_n_q   <= cs_n_nxt;
      done_q   <= done_nxt;
      sample_q <= sample_nxt;
      shift_q  <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (go) begin
`ifdef SPI_SCLK_GEN_GUARD_EN
          state_nxt = S_SETUP;
`else
          state_nxt = S_RUN;
`endif
        end
      end
`ifdef SPI_SCLK_GEN_GUARD_EN
      S_SETUP: begin
        if (bus.abort)  state_nxt = S_IDLE;
        else if (hc_tc) state_nxt = S_RUN;
      end
      S_HOLD: begin
        if (bus.abort || hc_tc) state_nxt = S_IDLE;
      end
`endif
      S_RUN: begin
        if (bus.abort) state_nxt = S_IDLE;
        else if (ec == ec_last) begin
`ifdef SPI_SCLK_GEN_GUARD_EN
          state_nxt = S_HOLD;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered-output and datapath next values; strobes land in the same cycle as the sclk edge.
  always_comb begin
    hc_nxt      = hc;
    ec_nxt      = ec;
    div_l_nxt   = div_l;
    nbits_l_nxt = nbits_l;
    cpol_l_nxt  = cpol_l;
    cpha_l_nxt  = cpha_l;
    sclk_nxt    = sclk_q;
    busy_nxt    = busy_q;
    cs_n_nxt    = cs_n_q;
    done_nxt    = 1'b0;
    sample_nxt  = 1'b0;
    shift_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        sclk_nxt = bus.cpol;
        hc_nxt   = '0;
        ec_nxt   = '0;
        busy_nxt = 1'b0;
        cs_n_nxt = 1'b1;
        if (go) begin
          div_l_nxt   = bus.div;
          nbits_l_nxt = bus.nbits;
          cpol_l_nxt  = bus.cpol;
          cpha_l_nxt  = bus.cpha;
          busy_nxt    = 1'b1;
          cs_n_nxt    = 1'b0;
        end else if (empty_go) begin
          done_nxt = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          hc_nxt   = '0;
          ec_nxt   = '0;
          sclk_nxt = cpol_l;
          busy_nxt = 1'b0;
          cs_n_nxt = 1'b1;
        end else if (ec == ec_last) begin
          hc_nxt = '0;
          ec_nxt = '0;
`ifndef SPI_SCLK_GEN_GUARD_EN
          busy_nxt = 1'b0;
          cs_n_nxt = 1'b1;
          done_nxt = 1'b1;
`endif
        end else if (hc_tc) begin
          hc_nxt   = '0;
          ec_nxt   = ec_inc;
          sclk_nxt = ~sclk_q;
          if (cpha_l) begin
            shift_nxt  = ec_inc[0];
            sample_nxt = ~ec_inc[0];
          end else begin
            sample_nxt = ec_inc[0];
            shift_nxt  = ~ec_inc[0] && (ec_inc != ec_last);
          end
        end else begin
          hc_nxt = hc + 1'b1;
        end
      end
`ifdef SPI_SCLK_GEN_GUARD_EN
      S_SETUP, S_HOLD: begin
        if (bus.abort) begin
          hc_nxt   = '0;
          ec_nxt   = '0;
          sclk_nxt = cpol_l;
          busy_nxt = 1'b0;
          cs_n_nxt = 1'b1;
        end else if (hc_tc) begin
          hc_nxt = '0;
          if (state == S_HOLD) begin
            busy_nxt = 1'b0;
            cs_n_nxt = 1'b1;
            done_nxt = 1'b1;
          end
        end else begin
          hc_nxt = hc + 1'b1;
        end
      end
`endif
      default: begin
        hc_nxt   = '0;
        ec_nxt   = '0;
        busy_nxt = 1'b0;
        cs_n_nxt = 1'b1;
      end
    endcase
  end

  assign bus.sclk   = sclk_q;
  assign bus.busy   = busy_q;
  assign bus.cs_n   = cs_n_q;
  assign bus.done   = done_q;
  assign bus.sample = sample_q;
  assign bus.shift  = shift_q;
endmodule

// File: tb/tb_spi_sclk_gen.sv
// Self-checking bench for spi_sclk_gen: directed table, abort/reset sequences and randomized transfers
// compared cycle by cycle against a closed-form timing model.
module tb_spi_sclk_gen;
`ifdef SPI_SCLK_GEN_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic busy;
    logic done;
    logic cs_n;
    logic sclk;
    logic sample;
    logic shift;
  } exp_t;

  typedef struct {
    int dv;
    bit cp;
    bit ch;
    int n;
    bit pert;
    int exp_done;
    int exp_edges;
    int exp_first;
    int exp_smp;
    int exp_shf;
  } vec_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  spi_sclk_gen_if #(.DIV_W(16), .CNT_W(6)) bus ();
  spi_sclk_gen #(.DIV_W(16), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  // Expected outputs c cycles after start was sampled, from edge-time arithmetic.
  function automatic exp_t model(input int c, input int dv, input bit cp, input bit ch, input int n);
    exp_t e;
    int p, g, endc, kk, rem, k;
    e = '{busy: 1'b0, done: 1'b0, cs_n: 1'b1, sclk: cp, sample: 1'b0, shift: 1'b0};
    if (n == 0) begin
      e.done = (c == 1);
      return e;
    end
    p    = dv + 1;
    g    = GUARD ? p : 0;
    endc = 2 + (2 * n + (GUARD ? 2 : 0)) * p;
    if (c >= 1 && c < endc) begin
      e.busy = 1'b1;
      e.cs_n = 1'b0;
    end
    e.done = (c == endc);
    if (c >= 1 + g) begin
      kk  = (c - 1 - g) / p;
      rem = (c - 1 - g) % p;
      k   = (kk > 2 * n) ? 2 * n : kk;
      e.sclk = cp ^ k[0];
      if (rem == 0 && kk >= 1 && kk <= 2 * n) begin
        if (ch) begin
          e.shift  = kk[0];
          e.sample = !kk[0];
        end else begin
          e.sample = kk[0];
          e.shift  = !kk[0] && (kk != 2 * n);
        end
      end
    end
    return e;
  endfunction

  function automatic exp_t cur();
    return {bus.busy, bus.done, bus.cs_n, bus.sclk, bus.sample, bus.shift};
  endfunction

  task automatic check(input string name, input int c, input exp_t want);
    exp_t got;
    got = cur();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s c=%0d got busy,done,cs_n,sclk,sample,shift=%b want %b", name, c, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic set_cfg(input int dv, input bit cp, input bit ch, input int n);
    bus.div   = 16'(dv);
    bus.cpol  = cp;
    bus.cpha  = ch;
    bus.nbits = 6'(n);
  endtask

  // Called at a negedge; start is sampled at the following posedge (cycle c=0 boundary).
  task automatic run_xfer(input string name, input int dv, input bit cp, input bit ch, input int n,
                          input bit pert, output int done_c, output int edges, output int first,
                          output int nsmp, output int nshf);
    int   endc;
    bit   prev;
    exp_t a;
    endc   = (n == 0) ? 1 : 2 + (2 * n + (GUARD ? 2 : 0)) * (dv + 1);
    done_c = 0;
    edges  = 0;
    first  = 0;
    nsmp   = 0;
    nshf   = 0;
    prev   = cp;
    set_cfg(dv, cp, ch, n);
    bus.abort = 1'b0;
    bus.start = 1'b1;
    for (int c = 1; c <= endc + 1; c++) begin
      @(negedge clk);
      a = cur();
      check(name, c, model(c, dv, cp, ch, n));
      if (a.done && done_c == 0) done_c = c;
      if (a.sclk != prev) begin
        edges++;
        if (first == 0) first = c;
      end
      prev = a.sclk;
      if (a.sample) nsmp++;
      if (a.shift) nshf++;
      if (c == 1) bus.start = 1'b0;
      if (pert && c > 1 && c < endc) begin
        bus.start = 1'($urandom_range(0, 1));
        set_cfg($urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 63));
      end
      if (c == endc) begin
        bus.start = 1'b0;
        set_cfg(dv, cp, ch, n);
      end
    end
  endtask

  vec_t tbl[5];
  exp_t idle_e;
  int   dc, ed, fe, ns, nh, p, g, ab;

  initial begin
    vectors     = 0;
    miscompares = 0;
    tbl[0] = '{1, 1'b0, 1'b0, 8, 1'b0, GUARD ? 38 : 34, 16, GUARD ? 5 : 3, 8, 7};
    tbl[1] = '{0, 1'b1, 1'b1, 3, 1'b0, GUARD ? 10 : 8, 6, GUARD ? 3 : 2, 3, 3};
    tbl[2] = '{1, 1'b0, 1'b0, 0, 1'b0, 1, 0, 0, 0, 0};
    tbl[3] = '{2, 1'b0, 1'b1, 5, 1'b1, GUARD ? 38 : 32, 10, GUARD ? 7 : 4, 5, 5};
    tbl[4] = '{1, 1'b0, 1'b0, 2, 1'b0, GUARD ? 14 : 10, 4, GUARD ? 5 : 3, 2, 1};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_cfg(3, 1'b0, 1'b0, 4);
    repeat (2) @(negedge clk);
    check("reset", 0, 6'b001000);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 0, 6'b001000);

    foreach (tbl[i]) begin
      run_xfer($sformatf("tbl%0d", i), tbl[i].dv, tbl[i].cp, tbl[i].ch, tbl[i].n, tbl[i].pert,
               dc, ed, fe, ns, nh);
      check_int($sformatf("tbl%0d_done_cycle", i), dc, tbl[i].exp_done);
      check_int($sformatf("tbl%0d_edges", i), ed, tbl[i].exp_edges);
      check_int($sformatf("tbl%0d_first_edge", i), fe, tbl[i].exp_first);
      check_int($sformatf("tbl%0d_samples", i), ns, tbl[i].exp_smp);
      check_int($sformatf("tbl%0d_shifts", i), nh, tbl[i].exp_shf);
    end

    // start together with abort in IDLE must not begin a transfer.
    set_cfg(1, 1'b1, 1'b0, 8);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    idle_e = '{busy: 1'b0, done: 1'b0, cs_n: 1'b1, sclk: 1'b1, sample: 1'b0, shift: 1'b0};
    check("start_abort_idle", 1, idle_e);
    @(negedge clk);
    check("start_abort_idle", 2, idle_e);

    // Abort in the cycle showing edge 5 of an 8-bit mode-2 transfer.
    p  = 2;
    g  = GUARD ? p : 0;
    ab = 1 + g + 5 * p;
    bus.start = 1'b1;
    for (int c = 1; c <= ab; c++) begin
      @(negedge clk);
      check("abort_pre", c, model(c, 1, 1'b1, 1'b0, 8));
      if (c == 1) bus.start = 1'b0;
    end
    bus.abort = 1'b1;
    @(negedge clk);
    check("abort_next", ab + 1, idle_e);
    bus.abort = 1'b0;
    for (int c = ab + 2; c <= ab + 4; c++) begin
      @(negedge clk);
      check("abort_quiet", c, idle_e);
    end
    run_xfer("after_abort", 1, 1'b1, 1'b0, 8, 1'b0, dc, ed, fe, ns, nh);
    check_int("after_abort_done_cycle", dc, GUARD ? 38 : 34);

    // Asynchronous reset between clock edges in the middle of a transfer.
    set_cfg(2, 1'b1, 1'b1, 4);
    bus.start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("rst_pre", c, model(c, 2, 1'b1, 1'b1, 4));
      if (c == 1) bus.start = 1'b0;
    end
    #2 rst = 1'b1;
    #1 check("rst_async", 0, 6'b001000);
    @(negedge clk);
    check("rst_held", 0, 6'b001000);
    rst = 1'b0;
    @(negedge clk);
    run_xfer("after_rst", 2, 1'b1, 1'b1, 4, 1'b1, dc, ed, fe, ns, nh);
    check_int("after_rst_done_cycle", dc, GUARD ? 32 : 26);

    for (int r = 0; r < 25; r++) begin
      int dv, n;
      bit cp, ch, pt;
      dv = $urandom_range(0, 4);
      cp = 1'($urandom_range(0, 1));
      ch = 1'($urandom_range(0, 1));
      n  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 9);
      pt = (n != 0) && ($urandom_range(0, 1) == 1);
      run_xfer($sformatf("rand%0d", r), dv, cp, ch, n, pt, dc, ed, fe, ns, nh);
      check_int($sformatf("rand%0d_edges", r), ed, 2 * n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
